// File: rtl/pa_noc.sv
// pa_noc: packet layout shared between the network interface and the router.
package pa_noc;
    localparam int PACKET_WIDTH = 75;
    localparam int COORD_W      = 2;
    localparam int ADDR_W       = 32;
    localparam int DATA_W       = 32;
    localparam int DST_COL_LSB  = 0;
    localparam int DST_ROW_LSB  = 2;
    localparam int SRC_COL_LSB  = 4;
    localparam int SRC_ROW_LSB  = 6;
    localparam int IS_RESP_BIT  = 8;
    localparam int WRITE_BIT    = 9;
    localparam int SLVERR_BIT   = 10;
    localparam int ADDR_LSB     = 11;
    localparam int DATA_LSB     = 43;

    typedef struct packed {
        logic [DATA_W-1:0]  data;
        logic [ADDR_W-1:0]  addr;
        logic               slverr;
        logic               write;
        logic               is_response;
        logic [COORD_W-1:0] src_row;
        logic [COORD_W-1:0] src_col;
        logic [COORD_W-1:0] dst_row;
        logic [COORD_W-1:0] dst_col;
    } packet_t;
endpackage

// File: rtl/network_interface.sv
// network_interface: APB completer that turns each transfer into a request packet
// toward the mesh and completes it on the matching response or a timeout.
module network_interface
    import pa_noc::*;
#(
    parameter int GRID_WIDTH     = 4,
    parameter int NI_ROW         = 0,
    parameter int NI_COL         = 0,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                    i_clk,
    input  logic                    i_arst_n,
    input  logic                    i_psel,
    input  logic                    i_penable,
    input  logic                    i_pwrite,
    input  logic [31:0]             i_paddr,
    input  logic [31:0]             i_pwdata,
    output logic [31:0]             o_prdata,
    output logic                    o_pready,
    output logic                    o_pslverr,
    output logic [PACKET_WIDTH-1:0] o_pkt,
    output logic                    o_pktValid,
    input  logic                    i_pktReady,
    input  logic [PACKET_WIDTH-1:0] i_pkt,
    input  logic                    i_pktValid,
    output logic                    o_pktReady
);
    localparam int CW = $clog2(GRID_WIDTH);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] SEND = 2'd1;
    localparam logic [1:0] WAIT = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    logic [1:0]    state;
    logic [31:0]   addr;
    logic [31:0]   wdata;
    logic          write;
    logic [CW-1:0] dst_row;
    logic [CW-1:0] dst_col;
    logic [TW-1:0] cnt;
    logic [31:0]   prdata;
    logic          slverr;
    packet_t       rsp;
    packet_t       req;
    logic          match;
    logic          is_local;
    logic          unused_rsp;

    assign rsp        = packet_t'(i_pkt);
    assign unused_rsp = ^{rsp.dst_row, rsp.dst_col, rsp.write, rsp.addr};
    // Only responses coming back from the node we addressed may complete the transfer.
    assign match      = i_pktValid && rsp.is_response &&
                        rsp.src_row == COORD_W'(dst_row) && rsp.src_col == COORD_W'(dst_col);
    assign is_local   = i_paddr[31 -: CW] == CW'(NI_ROW) && i_paddr[29 -: CW] == CW'(NI_COL);
    assign req        = '{data: wdata, addr: addr, slverr: 1'b0, write: write, is_response: 1'b0,
                          src_row: COORD_W'(NI_ROW), src_col: COORD_W'(NI_COL),
                          dst_row: COORD_W'(dst_row), dst_col: COORD_W'(dst_col)};

    assign o_pktValid = state == SEND;
    assign o_pkt      = o_pktValid ? req : '0;
    assign o_pktReady = 1'b1;
    assign o_pready   = state == DONE;
    assign o_prdata   = o_pready ? prdata : '0;
    assign o_pslverr  = o_pready & slverr;

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            state   <= IDLE;
            addr    <= '0;
            wdata   <= '0;
            write   <= 1'b0;
            dst_row <= '0;
            dst_col <= '0;
            cnt     <= '0;
            prdata  <= '0;
            slverr  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (i_psel && !i_penable) begin
                    addr    <= i_paddr;
                    write   <= i_pwrite;
                    wdata   <= i_pwrite ? i_pwdata : '0;
                    dst_row <= i_paddr[31 -: CW];
                    dst_col <= i_paddr[29 -: CW];
                    prdata  <= '0;
                    slverr  <= is_local;
                    state   <= is_local ? DONE : SEND;
                end
                SEND: if (i_pktReady) begin
                    cnt   <= '0;
                    state <= WAIT;
                end
                WAIT: if (match) begin
                    prdata <= write ? '0 : rsp.data;
                    slverr <= rsp.slverr;
                    state  <= DONE;
                end else if (cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                    prdata <= '0;
                    slverr <= 1'b1;
                    state  <= DONE;
                end else begin
                    cnt <= cnt + 1'b1;
                end
                default: begin
                    prdata <= '0;
                    slverr <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end
endmodule
